neuron_seq_ctrl: RTL and testbench
==================================

// Module: neuron_seq_ctrl
// PURPOSE
//  Sequences one perceptron neuron on FixedPoint::sfp (Q32.32) data: serial MAC over N_INPUTS streamed inputs,
//  bias add, then activation per Common::act_func. Step/ReLU are applied inline. Sigmoid/Tanh are dispatched to a
//  shared multi-cycle activation unit over a req/ack handshake. Sits between the input stream and the layer output.
// PARAMETERS
//  N_INPUTS  4                       inputs (and weights) per neuron, >=1
//  ADDR_W    $clog2(N_INPUTS)>1?..:1 weight address width
// PORTS
//  clk         in   1       clock
//  rst_n       in   1       synchronous active-low reset
//  w_we        in   1       weight write strobe (honoured only when busy=0)
//  w_addr      in   ADDR_W  weight index; indices >= N_INPUTS ignored
//  w_data      in   64      weight value, sfp
//  bias_we     in   1       bias write strobe (honoured only when busy=0)
//  bias_data   in   64      bias value, sfp
//  act_sel     in   act_func  activation, sampled on first input handshake
//  in_valid    in   1       input element valid
//  in_ready    out  1       high in IDLE and ACCUM
//  in_data     in   64      input element x_k, sfp, in order k=0..N_INPUTS-1
//  act_req     out  1       request to shared activation unit (WAIT state)
//  act_func_o  out  act_func  latched act_sel, valid while act_req=1
//  act_arg     out  64      pre-activation sum, valid while act_req=1
//  act_ack     in   1       result valid from activation unit; ignored if act_req=0
//  act_result  in   64      activation result, sampled when act_req&&act_ack
//  out_valid   out  1       neuron result valid (OUT state)
//  out_ready   in   1       consumer ready
//  out_data    out  64      neuron result, sfp; held until next result
//  busy        out  1       state != IDLE
// BEHAVIOUR
//  Reset (rst_n=0 at edge): state IDLE, acc=0, k=0, weights=0, bias=0, out_data=0, act_req/out_valid/busy=0.
//   Reset mid-operation aborts the neuron; no output, pending act_req dropped same edge.
//  FSM IDLE->ACCUM->BIAS->ACT->(OUT | WAIT->OUT)->IDLE.
//  IDLE: first in handshake: acc<=mul(x0,w[0]), k<=1, latch act_sel; ->ACCUM (->BIAS directly if N_INPUTS=1).
//  ACCUM: each handshake acc<=acc+mul(x_k,w[k]), k++; handshake with k=N_INPUTS-1 ->BIAS. No stall otherwise.
//  BIAS (1 cycle): acc<=acc+bias ->ACT.  ACT (1 cycle): Step: res=(acc>=0)?ONE:0; ReLU: res=(acc<0)?0:acc;
//   both ->OUT with out_data<=res. Sigmoid/Tanh ->WAIT.
//  WAIT: act_req=1, act_arg=acc, act_func_o held stable until act_ack sampled; on ack out_data<=act_result ->OUT.
//  OUT: out_valid=1 until out_valid&&out_ready; then ->IDLE (in_ready next cycle, no overlap).
//  Latency: last input handshake cycle c -> out_valid from c+3 (Step/ReLU); act_req from c+3; ack in cycle d ->
//   out_valid from d+1.
//  mul(a,b): 128-bit signed product, arithmetic >>>32, keep low 64 bits (truncate toward -inf, wrap).
//  Weight/bias writes while busy=1 are dropped; write at same edge as first in handshake is dropped.
// CONFIGURATION
//  NEURON_SAT_EN defined: every acc add (MAC and bias) detects signed overflow and clamps to
//   64'h7FFF_FFFF_FFFF_FFFF / 64'h8000_0000_0000_0000. Products still wrap.
//  Undefined: acc adds wrap modulo 2^64.
// STRUCTURE
//  FixedPoint pkg: sfp, frac_bits, ONE; add sfp_add_sat(a,b) there. Common pkg: act_func; add
//   typedef enum logic [2:0] {NS_IDLE,NS_ACCUM,NS_BIAS,NS_ACT,NS_WAIT,NS_OUT} neuron_state.
//  Sub-module sfp_mac_stage: combinational acc_in + mul(a,b) (b=0 for bias path reuse not required), honours NEURON_SAT_EN.
// TESTING  (N_INPUTS=4)
//  w={1.0,2.0,-1.0,0.5}, bias=-0.5, x={1,1,1,2}, ReLU -> out_data=64'h0000_0002_8000_0000 at c+3.
//  Same, Step -> 64'h0000_0001_0000_0000; bias=-4.0 -> ReLU 0, Step 0.
//  Same, Sigmoid: act_req at c+3, act_arg=64'h2_8000_0000, ack after 5 cycles with 64'hEE1E_xxxx ->
//   out_data=act_result at ack+1; act_arg/act_func_o stable throughout.
//  w all 64'h4000_0000_0000_0000, x all ONE, bias 0, ReLU: without NEURON_SAT_EN -> 0; with -> 64'h7FFF_FFFF_FFFF_FFFF.
//  out_ready low 10 cycles: out_valid/out_data held, in_ready=0; w_we during busy ignored (rerun same result).
//  rst_n low in WAIT with act_req=1: next cycle act_req=0, busy=0, weights read back 0 (rerun gives bias-only result).

Source files
------------

// File: rtl/neuron_seq_ctrl_pkg.sv
// neuron_seq_ctrl_pkg: Q32.32 fixed-point types/helpers, activation select, FSM states.
// NEURON_SAT_EN selects saturating accumulator adds; otherwise adds wrap mod 2^64.
package neuron_seq_ctrl_pkg;

  typedef logic signed [63:0] sfp;

  localparam int FRAC_BITS = 32;
  localparam sfp ONE     = 64'sh0000_0001_0000_0000;
  localparam sfp SFP_MAX = 64'sh7FFF_FFFF_FFFF_FFFF;
  localparam sfp SFP_MIN = 64'sh8000_0000_0000_0000;

  typedef enum logic [1:0] {
    ACT_STEP,
    ACT_RELU,
    ACT_SIGMOID,
    ACT_TANH
  } act_func;

  typedef enum logic [2:0] {
    NS_IDLE,
    NS_ACCUM,
    NS_BIAS,
    NS_ACT,
    NS_WAIT,
    NS_OUT
  } neuron_state;

  // Full 128-bit product, drop 32 fraction bits
  // (floor), keep low 64 bits (wrap).
  function automatic sfp sfp_mul(sfp a, sfp b);
    logic signed [127:0] p;
    p = a * b;
    return p[FRAC_BITS +: 64];
  endfunction

  function automatic sfp sfp_add_sat(sfp a, sfp b);
    sfp s;
    s = a + b;
    if (a[63] == b[63] && s[63] != a[63])
      s = a[63] ? SFP_MIN : SFP_MAX;
    return s;
  endfunction

  function automatic sfp sfp_acc_add(sfp a, sfp b);
`ifdef NEURON_SAT_EN
    return sfp_add_sat(a, b);
`else
    return a + b;
`endif
  endfunction

endpackage

// File: rtl/sfp_mac_stage.sv
// sfp_mac_stage: combinational acc_out = acc_in + mul(a, b).
// Ports: acc_in, a, b (sfp) -> acc_out (sfp); NEURON_SAT_EN clamps the add.
module sfp_mac_stage
  import neuron_seq_ctrl_pkg::*;
(
  input  sfp acc_in,
  input  sfp a,
  input  sfp b,
  output sfp acc_out
);

  assign acc_out = sfp_acc_add(acc_in, sfp_mul(a, b));

endmodule

// File: rtl/neuron_seq_ctrl.sv
// neuron_seq_ctrl: serial MAC + bias + activation for one Q32.32 neuron.
// Ports: weight/bias write, input stream, act unit req/ack, output stream; NEURON_SAT_EN.
module neuron_seq_ctrl
  import neuron_seq_ctrl_pkg::*;
#(
  parameter int N_INPUTS = 4,
  parameter int ADDR_W =
    ($clog2(N_INPUTS) > 1) ? $clog2(N_INPUTS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              w_we,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [63:0]       w_data,
  input  logic              bias_we,
  input  logic [63:0]       bias_data,
  input  act_func           act_sel,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [63:0]       in_data,
  output logic              act_req,
  output act_func           act_func_o,
  output logic [63:0]       act_arg,
  input  logic              act_ack,
  input  logic [63:0]       act_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [63:0]       out_data,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] K_LAST =
    ADDR_W'(N_INPUTS - 1);

  neuron_state       state;
  neuron_state       state_nx;
  sfp                acc;
  sfp                bias;
  sfp                w [N_INPUTS];
  sfp                mac_in;
  sfp                mac_out;
  sfp                res;
  logic [ADDR_W-1:0] k;
  logic [ADDR_W-1:0] k_idx;
  act_func           act_lat;
  logic              in_hs;
  logic              cfg_ok;
  logic              act_inline;

  assign in_ready   = (state == NS_IDLE) ||
                      (state == NS_ACCUM);
  assign in_hs      = in_valid && in_ready;
  assign busy       = (state != NS_IDLE);
  assign act_req    = (state == NS_WAIT);
  assign out_valid  = (state == NS_OUT);
  assign act_arg    = acc;
  assign act_func_o = act_lat;

  // A write racing the first input handshake
  // would change weights mid-neuron: drop it.
  assign cfg_ok = !busy && !in_hs;

  // First product starts a fresh sum from w[0].
  assign mac_in = (state == NS_IDLE) ? '0 : acc;
  assign k_idx  = busy ? k : '0;

  sfp_mac_stage u_mac (
    .acc_in  (mac_in),
    .a       (in_data),
    .b       (w[k_idx]),
    .acc_out (mac_out)
  );

  assign act_inline = (act_lat == ACT_STEP) ||
                      (act_lat == ACT_RELU);

  always_comb begin
    res = '0;
    unique case (act_lat)
      ACT_STEP: res = acc[63] ? '0 : ONE;
      ACT_RELU: res = acc[63] ? '0 : acc;
      default:  res = '0;
    endcase
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      NS_IDLE:
        if (in_hs)
          state_nx = (N_INPUTS == 1) ? NS_BIAS
                                     : NS_ACCUM;
      NS_ACCUM:
        if (in_hs && k == K_LAST)
          state_nx = NS_BIAS;
      NS_BIAS: state_nx = NS_ACT;
      NS_ACT:
        state_nx = act_inline ? NS_OUT : NS_WAIT;
      NS_WAIT:
        if (act_ack) state_nx = NS_OUT;
      NS_OUT:
        if (out_ready) state_nx = NS_IDLE;
      default: state_nx = NS_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= NS_IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc      <= '0;
      bias     <= '0;
      k        <= '0;
      out_data <= '0;
      act_lat  <= ACT_STEP;
      for (int i = 0; i < N_INPUTS; i++)
        w[i] <= '0;
    end else begin
      if (cfg_ok && w_we &&
          int'(w_addr) < N_INPUTS)
        w[w_addr] <= w_data;
      if (cfg_ok && bias_we)
        bias <= bias_data;
      unique case (state)
        NS_IDLE:
          if (in_hs) begin
            acc     <= mac_out;
            k       <= ADDR_W'(1);
            act_lat <= act_sel;
          end
        NS_ACCUM:
          if (in_hs) begin
            acc <= mac_out;
            k   <= k + 1'b1;
          end
        NS_BIAS: acc <= sfp_acc_add(acc, bias);
        NS_ACT:
          if (act_inline) out_data <= res;
        NS_WAIT:
          if (act_ack) out_data <= act_result;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_seq_ctrl.sv
// tb_neuron_seq_ctrl: directed + random neuron runs against a behavioural model.
// Checks latency, handshakes, write blocking, reset abort; NEURON_SAT_EN aware.
module tb_neuron_seq_ctrl;
  import neuron_seq_ctrl_pkg::*;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        w_we = 1'b0;
  logic [1:0]  w_addr = '0;
  logic [63:0] w_data = '0;
  logic        bias_we = 1'b0;
  logic [63:0] bias_data = '0;
  act_func     act_sel = ACT_STEP;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_data = '0;
  logic        act_req;
  act_func     act_func_o;
  logic [63:0] act_arg;
  logic        act_ack = 1'b0;
  logic [63:0] act_result = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_data;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [63:0] mw [N];
  logic [63:0] mb;
  logic [63:0] tx [N];
  logic [63:0] last_out;
  logic [63:0] prev_out;

  neuron_seq_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .w_we       (w_we),
    .w_addr     (w_addr),
    .w_data     (w_data),
    .bias_we    (bias_we),
    .bias_data  (bias_data),
    .act_sel    (act_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .act_req    (act_req),
    .act_func_o (act_func_o),
    .act_arg    (act_arg),
    .act_ack    (act_ack),
    .act_result (act_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: got %h expected %h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] m_mul(
      input logic [63:0] a, input logic [63:0] b);
    logic signed [127:0] p;
    p = $signed(a) * $signed(b);
    p = p >>> 32;
    return p[63:0];
  endfunction

  function automatic logic [63:0] m_add(
      input logic [63:0] a, input logic [63:0] b);
    logic signed [64:0] s;
    logic [63:0] r;
    s = $signed({a[63], a}) + $signed({b[63], b});
    r = s[63:0];
`ifdef NEURON_SAT_EN
    if (s > 65'sh0_7FFF_FFFF_FFFF_FFFF)
      r = 64'h7FFF_FFFF_FFFF_FFFF;
    else if (s < -65'sh0_8000_0000_0000_0000)
      r = 64'h8000_0000_0000_0000;
`endif
    return r;
  endfunction

  function automatic logic [63:0] m_pre();
    logic [63:0] acc;
    acc = '0;
    for (int i = 0; i < N; i++)
      acc = m_add(acc, m_mul(tx[i], mw[i]));
    return m_add(acc, mb);
  endfunction

  function automatic logic [63:0] m_act(
      input act_func a, input logic [63:0] v);
    if (a == ACT_STEP)
      return ($signed(v) >= 0) ? 64'h1_0000_0000 : 64'h0;
    return ($signed(v) < 0) ? 64'h0 : v;
  endfunction

  function automatic logic [63:0] rnd();
    logic [63:0] r;
    r = {$urandom, $urandom};
    if ($urandom_range(0, 3) != 0)
      r = 64'($signed(r) >>> $urandom_range(20, 36));
    return r;
  endfunction

  task automatic write_w(input int a,
                         input logic [63:0] d);
    w_we = 1'b1;
    w_addr = 2'(a);
    w_data = d;
    @(negedge clk);
    w_we = 1'b0;
    mw[a] = d;
  endtask

  task automatic write_b(input logic [63:0] d);
    bias_we = 1'b1;
    bias_data = d;
    @(negedge clk);
    bias_we = 1'b0;
    mb = d;
  endtask

  // Streams tx[], with a config write racing the
  // first handshake, then checks the 2 quiet cycles.
  task automatic feed(input act_func a);
    check("idle_ready", 64'(in_ready), 64'd1);
    check("idle_busy", 64'(busy), 64'd0);
    for (int k = 0; k < N; k++) begin
      in_valid = 1'b1;
      in_data = tx[k];
      act_sel = (k == 0) ? a :
        act_func'(2'($urandom_range(0, 3)));
      w_we = (k == 0);
      bias_we = (k == 0);
      w_addr = 2'($urandom_range(0, 3));
      w_data = {$urandom, $urandom};
      bias_data = {$urandom, $urandom};
      @(negedge clk);
    end
    in_valid = 1'b0;
    w_we = 1'b0;
    bias_we = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("lat_out_valid", 64'(out_valid), 64'd0);
      check("lat_act_req", 64'(act_req), 64'd0);
      check("lat_in_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
    end
  endtask

  task automatic run(input act_func a,
                     input int ack_dly,
                     input logic [63:0] ack_val,
                     input int stall);
    logic [63:0] pre;
    logic [63:0] exp;
    pre = m_pre();
    feed(a);
    if (a == ACT_STEP || a == ACT_RELU) begin
      exp = m_act(a, pre);
      check("out_valid_c3", 64'(out_valid), 64'd1);
      check("out_data", out_data, exp);
    end else begin
      exp = ack_val;
      check("act_req_c3", 64'(act_req), 64'd1);
      check("act_arg", act_arg, pre);
      check("act_func_o", 64'(act_func_o), 64'(a));
      check("wait_out_valid", 64'(out_valid), 64'd0);
      for (int i = 0; i < ack_dly; i++) begin
        @(negedge clk);
        check("wait_req", 64'(act_req), 64'd1);
        check("wait_arg", act_arg, pre);
        check("wait_func", 64'(act_func_o), 64'(a));
      end
      act_ack = 1'b1;
      act_result = ack_val;
      @(negedge clk);
      act_ack = 1'b0;
      act_result = {$urandom, $urandom};
      check("ack_out_valid", 64'(out_valid), 64'd1);
      check("ack_out_data", out_data, exp);
      check("ack_req_drop", 64'(act_req), 64'd0);
    end
    for (int i = 0; i < stall; i++) begin
      w_we = 1'b1;
      w_addr = 2'($urandom_range(0, 3));
      w_data = {$urandom, $urandom};
      bias_we = 1'b1;
      bias_data = {$urandom, $urandom};
      @(negedge clk);
      w_we = 1'b0;
      bias_we = 1'b0;
      check("stall_valid", 64'(out_valid), 64'd1);
      check("stall_data", out_data, exp);
      check("stall_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("done_valid", 64'(out_valid), 64'd0);
    check("done_busy", 64'(busy), 64'd0);
    check("done_ready", 64'(in_ready), 64'd1);
    check("held_data", out_data, exp);
    last_out = out_data;
  endtask

  task automatic load_spec();
    write_w(0, 64'h0000_0001_0000_0000);
    write_w(1, 64'h0000_0002_0000_0000);
    write_w(2, 64'hFFFF_FFFF_0000_0000);
    write_w(3, 64'h0000_0000_8000_0000);
    write_b(64'hFFFF_FFFF_8000_0000);
    tx[0] = 64'h1_0000_0000;
    tx[1] = 64'h1_0000_0000;
    tx[2] = 64'h1_0000_0000;
    tx[3] = 64'h2_0000_0000;
  endtask

  initial begin
    act_func a;
    for (int i = 0; i < N; i++) mw[i] = '0;
    mb = '0;

    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_act_req", 64'(act_req), 64'd0);
    check("rst_out_data", out_data, 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;
    @(negedge clk);

    load_spec();
    run(ACT_RELU, 0, '0, 0);
    check("spec_relu", last_out, 64'h2_8000_0000);
    run(ACT_STEP, 0, '0, 0);
    check("spec_step", last_out, 64'h1_0000_0000);
    write_b(64'hFFFF_FFFC_0000_0000);
    run(ACT_RELU, 0, '0, 0);
    check("neg_relu", last_out, 64'h0);
    run(ACT_STEP, 0, '0, 0);
    check("neg_step", last_out, 64'h0);
    write_b(64'hFFFF_FFFF_8000_0000);
    run(ACT_SIGMOID, 5, 64'hEE1E_0000_1234_5678, 0);
    check("spec_sigmoid", last_out,
          64'hEE1E_0000_1234_5678);

    run(ACT_RELU, 0, '0, 10);
    prev_out = last_out;
    run(ACT_RELU, 0, '0, 0);
    check("rerun_after_stall", last_out, prev_out);

    for (int i = 0; i < N; i++) begin
      write_w(i, 64'h4000_0000_0000_0000);
      tx[i] = 64'h1_0000_0000;
    end
    write_b(64'h0);
    run(ACT_RELU, 0, '0, 0);

    for (int it = 0; it < 12; it++) begin
      for (int i = 0; i < N; i++) begin
        write_w(i, rnd());
        tx[i] = rnd();
      end
      write_b(rnd());
      a = act_func'(2'($urandom_range(0, 3)));
      run(a, $urandom_range(0, 4),
          {$urandom, $urandom}, $urandom_range(0, 3));
    end

    load_spec();
    feed(ACT_TANH);
    check("pre_rst_req", 64'(act_req), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_req", 64'(act_req), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_valid", 64'(out_valid), 64'd0);
    for (int i = 0; i < N; i++) mw[i] = '0;
    mb = '0;
    write_b(64'h1_8000_0000);
    for (int i = 0; i < N; i++) tx[i] = rnd();
    run(ACT_RELU, 0, '0, 0);
    check("bias_only", last_out, 64'h1_8000_0000);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
